instr_decode_stage: RTL

//  Parametrised, registered instruction-decode stage for the LALU core.
//  - Accepts one fetched instruction word per valid/ready handshake and splits it into fields.
//  - Presents registered control strobes, register addresses and a resolved jump decision to execute.
//  - Holds a boot/run/halt state machine and uses ALU flags for conditional jumps.

---
 rtl/instr_decode_stage_pkg.sv | 43 ++++
 rtl/instr_decode_stage_if.sv | 50 +++++
 rtl/instr_decode_stage_comb.sv | 73 +++++++
 rtl/instr_decode_stage.sv | 107 ++++++++++
 4 files changed

// File: rtl/instr_decode_stage_pkg.sv
// -----------------------------------------------------------------------------
// lalu_isa_pkg
// Shared LALU instruction-set definitions for the decode stage:
//   - OPC_W and the OPC_* opcode encodings
//   - decoded_ctrl_t : control strobes, jump decision, halt and illegal flags
//   - fsm_state_t    : BOOT / RUN / HALTED stage states
// -----------------------------------------------------------------------------
package lalu_isa_pkg;

    localparam int OPC_W = 32'd4;

    localparam logic [3:0] OPC_NOP = 4'b0000;
    localparam logic [3:0] OPC_JMP = 4'b0001;
    localparam logic [3:0] OPC_JN  = 4'b0010;
    localparam logic [3:0] OPC_JZ  = 4'b0011;
    localparam logic [3:0] OPC_ADD = 4'b0100;
    localparam logic [3:0] OPC_SUB = 4'b0101;
    localparam logic [3:0] OPC_MOV = 4'b0110;
    localparam logic [3:0] OPC_OUT = 4'b0111;
    localparam logic [3:0] OPC_ST  = 4'b1011;
    localparam logic [3:0] OPC_LDI = 4'b1110;
    localparam logic [3:0] OPC_LD  = 4'b1111;

    typedef struct packed {
        logic reg_wr;
        logic mem_wr;
        logic ld;
        logic ldi;
        logic mov;
        logic sub;
        logic out_wr;
        logic jump;
        logic halt;
        logic illegal;
    } decoded_ctrl_t;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fsm_state_t;

endpackage

// File: rtl/instr_decode_stage_if.sv
// -----------------------------------------------------------------------------
// instr_decode_stage_if
// Fetch-side and execute-side handshake bundle of the decode stage.
//   fetch  : in_valid, in_ready, instr, alu_result
//   execute: out_valid, out_ready, rd, rs, jmp_addr, jump, control strobes,
//            halt, illegal
// Modports: slave = decode stage, master = surrounding fetch/execute logic.
// -----------------------------------------------------------------------------
interface instr_decode_stage_if
    import lalu_isa_pkg::*;
#(
    parameter int REG_ADDR_W = 32'd2,
    parameter int DATA_W     = 32'd16
);
    localparam int INSTR_W = OPC_W + 2 * REG_ADDR_W;
    localparam int JADDR_W = 2 * REG_ADDR_W;

    logic                  in_valid;
    logic                  in_ready;
    logic [INSTR_W-1:0]    instr;
    logic [DATA_W-1:0]     alu_result;
    logic                  out_valid;
    logic                  out_ready;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rs;
    logic [JADDR_W-1:0]    jmp_addr;
    logic                  jump;
    logic                  reg_wr;
    logic                  mem_wr;
    logic                  ld;
    logic                  ldi;
    logic                  mov;
    logic                  sub;
    logic                  out_wr;
    logic                  halt;
    logic                  illegal;

    modport slave (
        input  in_valid, instr, alu_result, out_ready,
        output in_ready, out_valid, rd, rs, jmp_addr, jump,
               reg_wr, mem_wr, ld, ldi, mov, sub, out_wr, halt, illegal
    );

    modport master (
        output in_valid, instr, alu_result, out_ready,
        input  in_ready, out_valid, rd, rs, jmp_addr, jump,
               reg_wr, mem_wr, ld, ldi, mov, sub, out_wr, halt, illegal
    );

endinterface

// File: rtl/instr_decode_stage_comb.sv
// -----------------------------------------------------------------------------
// instr_decode_comb
// Purely combinational opcode decoder: instruction word + live ALU result
// -> decoded_ctrl_t (strobes, jump decision, halt, illegal).
// Ports:
//   instr_i      : instruction word, [3:0] = opcode, upper bits = Rd/Rs
//   alu_result_i : ALU flag source (MSB = negative, all-zero = zero)
//   ctrl_o       : decoded control bundle
// Build option: DECODE_JZ_EN enables opcode 0011 as JZ; otherwise it is illegal.
// -----------------------------------------------------------------------------
module instr_decode_comb
    import lalu_isa_pkg::*;
#(
    parameter  int REG_ADDR_W = 32'd2,
    parameter  int DATA_W     = 32'd16,
    localparam int INSTR_W    = OPC_W + 2 * REG_ADDR_W
) (
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [DATA_W-1:0]  alu_result_i,
    output decoded_ctrl_t      ctrl_o
);

    logic [OPC_W-1:0] opc_s;
    logic             halt_regs_s;

    assign opc_s       = instr_i[OPC_W-1:0];
    // HALT is a MOV whose Rd and Rs fields are all ones
    assign halt_regs_s = &instr_i[INSTR_W-1:OPC_W];

`ifndef DECODE_JZ_EN
    // Only the sign bit is consumed when JZ is not built in
    logic unused_alu_low_s;
    assign unused_alu_low_s = ^alu_result_i[DATA_W-2:0];
`endif

    // Opcode to control-bundle decode
    always_comb begin
        ctrl_o = '0;
        case (opc_s)
            OPC_NOP: ctrl_o = '0;
            OPC_JMP: ctrl_o.jump = 1'b1;
            OPC_JN:  ctrl_o.jump = alu_result_i[DATA_W-1];
`ifdef DECODE_JZ_EN
            OPC_JZ:  ctrl_o.jump = (alu_result_i == '0);
`endif
            OPC_ADD: ctrl_o.reg_wr = 1'b1;
            OPC_SUB: begin
                ctrl_o.reg_wr = 1'b1;
                ctrl_o.sub    = 1'b1;
            end
            OPC_MOV: begin
                ctrl_o.mov = 1'b1;
                if (halt_regs_s) begin
                    ctrl_o.halt = 1'b1;
                end else begin
                    ctrl_o.reg_wr = 1'b1;
                end
            end
            OPC_OUT: ctrl_o.out_wr = 1'b1;
            OPC_ST:  ctrl_o.mem_wr = 1'b1;
            OPC_LDI: begin
                ctrl_o.reg_wr = 1'b1;
                ctrl_o.ldi    = 1'b1;
            end
            OPC_LD:  begin
                ctrl_o.reg_wr = 1'b1;
                ctrl_o.ld     = 1'b1;
            end
            default: ctrl_o.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_decode_stage.sv
// -----------------------------------------------------------------------------
// instr_decode_stage
// Registered LALU instruction-decode stage with BOOT/RUN/HALTED control.
// Ports:
//   clk : clock, all state on rising edge
//   rst : synchronous active-high reset
//   bus : instr_decode_stage_if.slave - fetch handshake (in_valid/in_ready,
//         instr, alu_result) and execute handshake (out_valid/out_ready, rd,
//         rs, jmp_addr, jump, reg_wr, mem_wr, ld, ldi, mov, sub, out_wr,
//         halt, illegal)
// Build option: DECODE_JZ_EN (see instr_decode_comb).
// One-cycle latency; back-to-back accepts run at full rate. All execute-side
// outputs are zero whenever out_valid is low.
// -----------------------------------------------------------------------------
module instr_decode_stage
    import lalu_isa_pkg::*;
#(
    parameter int REG_ADDR_W = 32'd2,
    parameter int DATA_W     = 32'd16
) (
    input logic                  clk,
    input logic                  rst,
    instr_decode_stage_if.slave  bus
);

    localparam int INSTR_W = OPC_W + 2 * REG_ADDR_W;
    localparam int JADDR_W = 2 * REG_ADDR_W;

    fsm_state_t            state_q;
    decoded_ctrl_t         ctrl_d;
    decoded_ctrl_t         ctrl_q;
    logic                  out_valid_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [REG_ADDR_W-1:0] rs_q;
    logic [JADDR_W-1:0]    jmp_addr_q;
    logic                  in_ready_s;
    logic                  accept_s;

    instr_decode_comb #(
        .REG_ADDR_W (REG_ADDR_W),
        .DATA_W     (DATA_W)
    ) u_decode (
        .instr_i      (bus.instr),
        .alu_result_i (bus.alu_result),
        .ctrl_o       (ctrl_d)
    );

    assign in_ready_s = (state_q == RUN) && (!out_valid_q || bus.out_ready);
    assign accept_s   = bus.in_valid && in_ready_s;

    // Stage state machine: one BOOT cycle, RUN until HALT is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BOOT;
        end else begin
            case (state_q)
                BOOT:    state_q <= RUN;
                RUN:     state_q <= (accept_s && ctrl_d.halt) ? HALTED : RUN;
                HALTED:  state_q <= HALTED;
                default: state_q <= BOOT;
            endcase
        end
    end

    // Output register: load on accept, clear once drained, hold while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            rd_q        <= '0;
            rs_q        <= '0;
            jmp_addr_q  <= '0;
            ctrl_q      <= '0;
        end else if (accept_s) begin
            out_valid_q <= 1'b1;
            rd_q        <= bus.instr[INSTR_W-1 -: REG_ADDR_W];
            rs_q        <= bus.instr[INSTR_W-1-REG_ADDR_W -: REG_ADDR_W];
            jmp_addr_q  <= bus.instr[INSTR_W-1:OPC_W];
            ctrl_q      <= ctrl_d;
        end else if (bus.out_ready) begin
            // Clearing the fields keeps every strobe qualified by out_valid
            out_valid_q <= 1'b0;
            rd_q        <= '0;
            rs_q        <= '0;
            jmp_addr_q  <= '0;
            ctrl_q      <= '0;
        end else begin
            out_valid_q <= out_valid_q;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_q;
    assign bus.rd        = rd_q;
    assign bus.rs        = rs_q;
    assign bus.jmp_addr  = jmp_addr_q;
    assign bus.jump      = ctrl_q.jump;
    assign bus.reg_wr    = ctrl_q.reg_wr;
    assign bus.mem_wr    = ctrl_q.mem_wr;
    assign bus.ld        = ctrl_q.ld;
    assign bus.ldi       = ctrl_q.ldi;
    assign bus.mov       = ctrl_q.mov;
    assign bus.sub       = ctrl_q.sub;
    assign bus.out_wr    = ctrl_q.out_wr;
    assign bus.halt      = ctrl_q.halt;
    assign bus.illegal   = ctrl_q.illegal;

endmodule
